run_detector_n: RTL
===================

# run_detector_n

Parametrised, multi-channel detector for runs of consecutive 1's on single-bit input streams. It generalises the fixed three-ones Mealy detector in four ways: a runtime threshold, overlapping or non-overlapping mode, a sample-enable qualifier, and per-channel run-length reporting. It sits between serial front-end logic and downstream event handling, and all channels share one clock, enable and configuration.

## Interface
- `CHANNELS`, default 1: number of independent bit streams (≥1).
- `CNT_W`, default 4: width of the per-channel run counter and the threshold (≥2).
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: reset, synchronous and active-low. Same clock as everything else.
- `en` input 1: sample strobe. `in` is evaluated only in cycles where `en`=1.
- `clr` input 1: synchronous clear of all run counters.
- `mode` input 1: 0 = overlapping (`out` stays high for every 1 beyond the threshold); 1 = non-overlapping (counter restarts after each hit).
- `thresh` input CNT_W: run length required for a hit. A value of 0 disables detection.
- `in` input CHANNELS: one data bit per channel.
- `out` output CHANNELS: Mealy hit, combinational from the current state and inputs.
- `out_q` output CHANNELS: `out` registered (one cycle later).
- `run_len` output CHANNELS*CNT_W: current count per channel, channel i at bits [i*CNT_W +: CNT_W].

## Operation
Each channel i holds a counter `cnt_i` (CNT_W bits) equal to the number of consecutive 1's accepted so far.

- `inc_i` = `cnt_i` + 1, computed at CNT_W+1 bits so there is no wrap in the comparison.
- `hit_i` = `reset_n` & ~`clr` & `en` & `in[i]` & (`thresh`≠0) & (`inc_i` ≥ `thresh`).
- `out[i]` = `hit_i`, so the hit shows in the same cycle as the thresh-th consecutive 1.

Next-state rules, evaluated in priority order:
1. `reset_n`=0: `cnt_i` ← 0, `out_q` ← 0.
2. `clr`=1: `cnt_i` ← 0. `out_q` ← 0.
3. `en`=0: `cnt_i` holds. `out_q` ← 0.
4. `in[i]`=0: `cnt_i` ← 0.
5. `in[i]`=1 and `mode`=1 and `hit_i`: `cnt_i` ← 0. The next run starts fresh.
6. `in[i]`=1 otherwise: `cnt_i` ← min(`inc_i`, 2^CNT_W−1). The counter saturates at its maximum.

Other rules:
- `out_q[i]` ← `hit_i` every cycle when not in reset.
- `run_len` shows the registered `cnt_i` directly.
- Channels never interact with each other.
- `thresh` and `mode` are not latched. A change applies to the comparison in the same cycle, and the counters are not cleared.
- Switching to `mode`=1 while `cnt_i` ≥ `thresh` fires on the next accepted 1 and clears the counter.
- If `thresh` exceeds 2^CNT_W−1 + 1, no hit is possible. `thresh` = 2^CNT_W−1 is reachable; in overlapping mode, saturation keeps firing.
- `thresh`=1: every accepted 1 is a hit. In mode 1, the counter stays at 0.

## Timing
- Reset values: `cnt_i`=0, `run_len`=0, `out_q`=0. `out`=0 whenever `reset_n`=0, regardless of `in`.
- Latency:
  - `out`: 0 cycles from the qualifying `in`/`en` sample (combinational).
  - `out_q` and `run_len`: 1 cycle.
- A reset or `clr` in the middle of a run drops the partial count. A run must then restart from its first 1.
- `en` gaps are transparent: 1,(en=0),1,1 counts as three consecutive 1's.
- `clr` and `en` together: `clr` wins, no hit, the counter goes to 0.
- No combinational path from `out` back to any input. Inputs must be stable before the rising edge of `clk`.

## Test plan
1. Baseline, overlapping. CHANNELS=1, CNT_W=4, `thresh`=3, `mode`=0, `en`=1, `in`=1,1,1,1,0,1,1,0,1,1,1 → `out` = 0,0,1,1,0,0,0,0,0,0,1; `run_len` (next cycle) = 1,2,3,4,0,1,2,0,1,2,3.
2. Non-overlapping. Same setup with `mode`=1, `in`=1×7 → `out` high on the 3rd and 6th ones only; `run_len` = 1,2,0,1,2,0,1.
3. Enable and clear. `thresh`=3, `in`=1 held, `en`=1,0,1,1 → hit on the 4th cycle. Then `clr`=1 while `in`=1 → `out`=0 and `run_len`=0, and the next hit needs three more accepted 1's.
4. Saturation and edge thresholds. CNT_W=3, `mode`=0:
   - `thresh`=7, `in`=1×10 → `run_len` sticks at 7, and `out` is high from the 7th one onward.
   - `thresh`=0 → `out` is never asserted, while `run_len` still counts.
   - `thresh`=1, `mode`=1 → `out`=`in` and `run_len` stays at 0.
5. Multi-channel independence. CHANNELS=4, `thresh`=2, `in`=4'b0001,4'b0011,4'b0111,4'b1110 → `out` = 0000, 0001, 0011, 0110; `run_len` = {0,0,0,1}, {0,0,1,2}, {0,1,2,3}, {1,2,3,0} (ch3..ch0, next cycle).
6. Reset mid-run. `thresh`=3, `in`=1,1, then `reset_n`=0 for 1 cycle, then `in`=1,1,1 → `out`=0 during reset, `out` asserts only on the 3rd one after release, and `out_q` follows one cycle later.

Source files
------------

// File: rtl/run_detector_n.sv
// Purpose : per-channel detector for runs of consecutive 1's with a runtime threshold,
//           overlapping / non-overlapping mode and an enable qualifier.
// Latency : out is combinational (0 cycles); out_q and run_len are registered (1 cycle).
// Backpress: none. Inputs are sampled only when en=1, and en=0 freezes the run counters.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   en       sample strobe; in[] is evaluated only when en=1
//   clr      synchronous clear of all run counters (wins over en)
//   mode     0 = overlapping hits, 1 = counter restarts after each hit
//   thresh   run length required for a hit; 0 disables detection
//   in       one data bit per channel
//   out      Mealy hit per channel (combinational)
//   out_q    out registered
//   run_len  registered run counter, channel i at [i*CNT_W +: CNT_W]
module run_detector_n #(
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      mode,
    input  logic [CNT_W-1:0]          thresh,
    input  logic [CHANNELS-1:0]       in,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       out_q,
    output logic [CHANNELS*CNT_W-1:0] run_len
);

    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_d;
    // One extra bit so a saturated counter still compares correctly against thresh.
    logic [CHANNELS-1:0][CNT_W:0]   inc;
    logic [CHANNELS-1:0]            hit;
    logic [CNT_W:0]                 thr_ext;
    logic                           thr_nz;

    assign thr_ext = {1'b0, thresh};
    assign thr_nz  = |thresh;

    always_comb begin
        inc   = '0;
        hit   = '0;
        cnt_d = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            inc[i] = {1'b0, cnt_q[i]} + 1'b1;
            hit[i] = reset_n & ~clr & en & in[i] & thr_nz & (inc[i] >= thr_ext);

            if (clr) begin
                cnt_d[i] = '0;
            end else if (!en) begin
                cnt_d[i] = cnt_q[i];              // en gaps are transparent to a run
            end else if (!in[i]) begin
                cnt_d[i] = '0;
            end else if (mode && hit[i]) begin
                cnt_d[i] = '0;                    // non-overlapping: next run starts fresh
            end else if (inc[i][CNT_W]) begin
                cnt_d[i] = '1;                    // saturate rather than wrap
            end else begin
                cnt_d[i] = inc[i][CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= hit;
        end
    end

    assign out     = hit;
    assign run_len = cnt_q;

endmodule
